// File: rtl/matmul_seq_engine.sv
// Sequential NxN integer matrix multiplier: one multiply-accumulate per clock,
// operands loaded through a write port, results read back through a registered port.
module matmul_seq_engine #(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  localparam int IW    = (N < 2) ? 1 : $clog2(N),
  localparam int ACC_W = 2 * DW + $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IW-1:0]    wr_row,
  input  logic [IW-1:0]    wr_col,
  input  logic [DW-1:0]    wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [IW-1:0]    rd_row,
  input  logic [IW-1:0]    rd_col,
  output logic [ACC_W-1:0] rd_data
);

  typedef enum logic {IDLE, COMPUTE} state_t;

  localparam logic [IW:0]   N_L  = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state, state_next;

  logic [DW-1:0]    mat_a [N][N];
  logic [DW-1:0]    mat_b [N][N];
  logic [ACC_W-1:0] mat_c [N][N];
  logic [ACC_W-1:0] acc, acc_next, prod, a_ext, b_ext;
  logic [IW-1:0]    i, j, k;
  logic             a_sign, b_sign;
  logic             wr_in_range, rd_in_range, wr_ok, err_next, last_mac;

  assign busy = (state == COMPUTE);

  always_comb begin
    wr_in_range = ({1'b0, wr_row} < N_L) && ({1'b0, wr_col} < N_L);
    rd_in_range = ({1'b0, rd_row} < N_L) && ({1'b0, rd_col} < N_L);
    wr_ok       = wr_en && (state == IDLE) && wr_in_range;
    err_next    = (wr_en && !wr_ok) || (start && (state == COMPUTE));
    last_mac    = (state == COMPUTE) && (i == LAST) && (j == LAST) && (k == LAST);
    state_next  = state;
    case (state)
      IDLE:    if (start) state_next = COMPUTE;
      COMPUTE: if (last_mac) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are widened to the accumulator width so the product and the sum
  // are both exact (two's complement when SIGNED is set).
  always_comb begin
    a_sign   = (SIGNED != 0) && mat_a[i][k][DW-1];
    b_sign   = (SIGNED != 0) && mat_b[k][j][DW-1];
    a_ext    = {{(ACC_W - DW){a_sign}}, mat_a[i][k]};
    b_ext    = {{(ACC_W - DW){b_sign}}, mat_b[k][j]};
    prod     = a_ext * b_ext;
    acc_next = (k == '0) ? prod : acc + prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_a[r][c] <= '0;
          mat_b[r][c] <= '0;
          mat_c[r][c] <= '0;
        end
      end
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      rd_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      rd_data <= rd_in_range ? mat_c[rd_row][rd_col] : '0;
      done    <= last_mac;
      err     <= err_next;
      if (wr_ok) begin
        if (wr_sel) mat_b[wr_row][wr_col] <= wr_data;
        else        mat_a[wr_row][wr_col] <= wr_data;
      end
      // Index order: k innermost, then j, then i.
      if ((state == IDLE) && start) begin
        i <= '0;
        j <= '0;
        k <= '0;
      end else if (state == COMPUTE) begin
        acc <= acc_next;
        if (k == LAST) begin
          mat_c[i][j] <= acc_next;
          k <= '0;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Self-checking bench for matmul_seq_engine: three instances (N=2 unsigned,
// N=2 signed, N=3 signed) compared against a plain-arithmetic matrix model.
module tb_matmul_seq_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] wr_en, start, busy, done, err;
  logic       wr_sel;
  logic [1:0] wr_row, wr_col, rd_row, rd_col;
  logic [7:0] wr_data;
  logic [16:0] rd0, rd1;
  logic [17:0] rd2;

  int total = 0;
  int bad   = 0;

  int          nsz  [3] = '{2, 2, 3};
  bit          sgn  [3] = '{1'b0, 1'b1, 1'b1};
  int          accw [3] = '{17, 17, 18};
  logic [7:0]  ma [3][4][4];
  logic [7:0]  mb [3][4][4];
  int          mc [3][4][4];

  always #5 clk = ~clk;

  matmul_seq_engine #(.N(2), .DW(8), .SIGNED(0)) dut_u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_sel(wr_sel),
    .wr_row(wr_row[0:0]), .wr_col(wr_col[0:0]), .wr_data(wr_data),
    .start(start[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .rd_row(rd_row[0:0]), .rd_col(rd_col[0:0]), .rd_data(rd0));

  matmul_seq_engine #(.N(2), .DW(8), .SIGNED(1)) dut_s2 (
    .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_sel(wr_sel),
    .wr_row(wr_row[0:0]), .wr_col(wr_col[0:0]), .wr_data(wr_data),
    .start(start[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .rd_row(rd_row[0:0]), .rd_col(rd_col[0:0]), .rd_data(rd1));

  matmul_seq_engine #(.N(3), .DW(8), .SIGNED(1)) dut_s3 (
    .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .start(start[2]), .busy(busy[2]), .done(done[2]), .err(err[2]),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd2));

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_rd(input int id);
    case (id)
      0:       return {15'd0, rd0};
      1:       return {15'd0, rd1};
      default: return {14'd0, rd2};
    endcase
  endfunction

  function automatic int masked(input int id, input int v);
    return v & ((1 << accw[id]) - 1);
  endfunction

  function automatic int opval(input int id, input logic [7:0] v);
    return sgn[id] ? int'($signed(v)) : int'(v);
  endfunction

  task automatic model_compute(input int id);
    for (int r = 0; r < nsz[id]; r++)
      for (int c = 0; c < nsz[id]; c++) begin
        mc[id][r][c] = 0;
        for (int x = 0; x < nsz[id]; x++)
          mc[id][r][c] += opval(id, ma[id][r][x]) * opval(id, mb[id][x][c]);
      end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ma[d][r][c] = '0;
          mb[d][r][c] = '0;
          mc[d][r][c] = 0;
        end
  endtask

  task automatic write_elem(input int id, input bit sel, input int r, input int c, input int v);
    bit reject;
    reject  = (r >= nsz[id]) || (c >= nsz[id]);
    wr_sel  = sel;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = 8'(v);
    wr_en[id] = 1'b1;
    tick();
    wr_en[id] = 1'b0;
    check_output("wr_err", int'(err[id]), int'(reject));
    if (!reject) begin
      if (sel) mb[id][r][c] = 8'(v);
      else     ma[id][r][c] = 8'(v);
    end
  endtask

  task automatic apply_stimulus(input int id, input int a[9], input int b[9]);
    for (int r = 0; r < nsz[id]; r++)
      for (int c = 0; c < nsz[id]; c++) begin
        write_elem(id, 1'b0, r, c, a[r * nsz[id] + c]);
        write_elem(id, 1'b1, r, c, b[r * nsz[id] + c]);
      end
  endtask

  task automatic load_random(input int id);
    int a[9], b[9];
    for (int x = 0; x < 9; x++) begin
      a[x] = int'($urandom_range(0, 255));
      b[x] = int'($urandom_range(0, 255));
    end
    apply_stimulus(id, a, b);
  endtask

  // inject_at > 0: write A[0][0]=9 and pulse start so they land on that edge.
  // start_wr: write A[2][2]=5 together with the start pulse.
  task automatic run(input int id, input int inject_at, input bit start_wr);
    int cyc, busy_cnt, err_cnt, n3;
    n3 = nsz[id] * nsz[id] * nsz[id];
    start[id] = 1'b1;
    if (start_wr) begin
      wr_sel = 1'b0; wr_row = 2'd2; wr_col = 2'd2; wr_data = 8'd5;
      wr_en[id] = 1'b1;
      ma[id][2][2] = 8'd5;
    end
    tick();
    start[id] = 1'b0;
    wr_en[id] = 1'b0;
    cyc = 0; busy_cnt = 0; err_cnt = 0;
    while (!done[id] && cyc < 200) begin
      if (busy[id]) busy_cnt++;
      if (err[id]) err_cnt++;
      if (inject_at > 0 && cyc == inject_at - 1) begin
        wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd9;
        wr_en[id] = 1'b1;
        start[id] = 1'b1;
      end
      tick();
      wr_en[id] = 1'b0;
      start[id] = 1'b0;
      cyc++;
    end
    if (err[id]) err_cnt++;
    check_output("done_latency", cyc, n3);
    check_output("busy_cycles", busy_cnt, n3);
    check_output("busy_at_done", int'(busy[id]), 0);
    check_output("err_pulses", err_cnt, (inject_at > 0) ? 1 : 0);
    tick();
    check_output("done_one_cycle", int'(done[id]), 0);
    model_compute(id);
  endtask

  task automatic read_one(input int id, input int r, input int c, output int v);
    rd_row = 2'(r);
    rd_col = 2'(c);
    tick();
    v = get_rd(id);
  endtask

  task automatic read_all(input int id, input string tag);
    int v;
    for (int r = 0; r < nsz[id]; r++)
      for (int c = 0; c < nsz[id]; c++) begin
        read_one(id, r, c, v);
        check_output(tag, v, masked(id, mc[id][r][c]));
      end
  endtask

  initial begin
    int v, done_seen;
    reset = 1'b0;
    wr_en = '0; start = '0; wr_sel = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0; rd_col = '0;
    clear_model();
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      check_output("rst_busy", int'(busy[d]), 0);
      check_output("rst_done", int'(done[d]), 0);
      check_output("rst_err", int'(err[d]), 0);
      check_output("rst_rd", get_rd(d), 0);
    end
    reset = 1'b1;
    tick();

    $display("[TB] basic N=2 product");
    apply_stimulus(0, '{1, 2, 3, 4, 0, 0, 0, 0, 0}, '{5, 6, 7, 8, 0, 0, 0, 0, 0});
    run(0, 0, 1'b0);
    read_all(0, "t1_c");
    read_one(0, 1, 1, v);
    check_output("t1_c11_const", v, 50);

    $display("[TB] unsigned full-scale operands");
    apply_stimulus(0, '{255, 255, 255, 255, 0, 0, 0, 0, 0}, '{255, 255, 255, 255, 0, 0, 0, 0, 0});
    run(0, 0, 1'b0);
    read_all(0, "t2_c");
    read_one(0, 0, 1, v);
    check_output("t2_c01_const", v, 130050);

    $display("[TB] signed N=2 product");
    apply_stimulus(1, '{-1, 2, 3, -4, 0, 0, 0, 0, 0}, '{5, -6, -7, 8, 0, 0, 0, 0, 0});
    run(1, 0, 1'b0);
    read_all(1, "t3_c");
    read_one(1, 0, 0, v);
    check_output("t3_c00_const", v, 131072 - 19);

    $display("[TB] rejected write and start during compute");
    apply_stimulus(0, '{1, 2, 3, 4, 0, 0, 0, 0, 0}, '{5, 6, 7, 8, 0, 0, 0, 0, 0});
    run(0, 3, 1'b0);
    read_all(0, "t4_c");

    $display("[TB] reset during compute");
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check_output("t5_busy_in_reset", int'(busy[0]), 0);
    check_output("t5_done_in_reset", int'(done[0]), 0);
    tick(); tick();
    reset = 1'b1;
    clear_model();
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done[0] || busy[0]) done_seen++;
    end
    check_output("t5_no_done_after_abort", done_seen, 0);
    read_all(0, "t5_c_cleared");
    read_all(2, "t5_c3_cleared");
    apply_stimulus(0, '{1, 2, 3, 4, 0, 0, 0, 0, 0}, '{5, 6, 7, 8, 0, 0, 0, 0, 0});
    run(0, 0, 1'b0);
    read_all(0, "t5_rerun_c");

    $display("[TB] N=3 bounds and start-cycle write");
    write_elem(2, 1'b0, 3, 0, 77);
    write_elem(2, 1'b1, 1, 3, 77);
    apply_stimulus(2, '{1, 0, 0, 0, 1, 0, 0, 0, 1}, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
    run(2, 0, 1'b1);
    read_all(2, "t6_c");
    read_one(2, 2, 2, v);
    check_output("t6_c22_const", v, 45);
    read_one(2, 3, 0, v);
    check_output("t6_rd_row_oob", v, 0);
    read_one(2, 0, 3, v);
    check_output("t6_rd_col_oob", v, 0);

    $display("[TB] randomized products");
    for (int rep = 0; rep < 4; rep++) begin
      for (int d = 0; d < 3; d++) begin
        load_random(d);
        run(d, 0, 1'b0);
        read_all(d, "rand_c");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
